lsu_mem_master: RTL and testbench

- Load/store initiator for the core. Sits between the execute stage and the word-indexed data memory.
- Takes one byte-addressed load or store per handshake and drives the memory's word address, read strobe, write strobe and write data.
- Implements RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW. Sub-word stores use read-modify-write because the memory has no byte enables.
- Returns extended load data, or an error for misaligned, out-of-range or illegal accesses.

---
 rtl/lsu_mem_master.sv | 211 +++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the execute stage and a word-indexed data memory.
// Handles RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW. Sub-word stores use read-modify-write
// because the memory has no byte enables. All outputs are registered.
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready         request handshake; ready only while idle
//   req_we/req_funct3           store flag and RISC-V size/sign code
//   req_addr/req_wdata          byte address and store data
//   resp_valid/resp_rdata/resp_err  one-cycle completion with load data or error
//   mem_addr/mem_re/mem_wr/mem_wdata/mem_rdata  word-indexed memory port
module lsu_mem_master #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_re,
  output logic             mem_wr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] READ     = 3'd1;
  localparam logic [2:0] RMW_READ = 3'd2;
  localparam logic [2:0] WRITE    = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  localparam logic [WIDTH-1:0] MEM_WORDS = WIDTH'(MEM_SIZE);

  logic [2:0]       state, next_state;

  // Request fields kept for the later phases of a transaction
  logic [2:0]       lat_funct3;
  logic [1:0]       lat_off;
  logic [15:0]      lat_wdata;

  logic             accept;
  logic             req_err;
  logic [WIDTH-1:0] req_word;

  logic             nxt_req_ready, nxt_resp_valid, nxt_resp_err, nxt_mem_re, nxt_mem_wr;
  logic [WIDTH-1:0] nxt_resp_rdata, nxt_mem_addr, nxt_mem_wdata;

  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] ld_data;
  logic [WIDTH-1:0] rmw_word;

  assign accept   = req_valid && req_ready;
  assign req_word = WIDTH'(req_addr[WIDTH-1:2]);

  // Request classification: illegal size code, misalignment, or out-of-range word
  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      if (req_funct3 > 3'd2) req_err = 1'b1;
    end else begin
      if (req_funct3 == 3'd3 || req_funct3 > 3'd5) req_err = 1'b1;
    end
    if (req_funct3[1:0] == 2'd1 && req_addr[0]) req_err = 1'b1;
    if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_word >= MEM_WORDS) req_err = 1'b1;
  end

  // Load lane select and extension (little-endian lanes)
  always_comb begin
    ld_byte = 8'h00;
    case (lat_off)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_funct3)
      3'd0:    ld_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
      3'd4:    ld_data = WIDTH'(ld_byte);
      3'd5:    ld_data = WIDTH'(ld_half);
      default: ld_data = mem_rdata;
    endcase
  end

  // Sub-word store merge into the word read back from memory
  always_comb begin
    rmw_word = mem_rdata;
    if (lat_funct3[1:0] == 2'd1) begin
      if (lat_off[1]) rmw_word[31:16] = lat_wdata;
      else            rmw_word[15:0]  = lat_wdata;
    end else begin
      case (lat_off)
        2'd0:    rmw_word[7:0]   = lat_wdata[7:0];
        2'd1:    rmw_word[15:8]  = lat_wdata[7:0];
        2'd2:    rmw_word[23:16] = lat_wdata[7:0];
        default: rmw_word[31:24] = lat_wdata[7:0];
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and next-output logic
  always_comb begin
    next_state     = state;
    nxt_resp_valid = 1'b0;
    nxt_mem_re     = 1'b0;
    nxt_mem_wr     = 1'b0;
    nxt_resp_rdata = resp_rdata;
    nxt_resp_err   = resp_err;
    nxt_mem_addr   = mem_addr;
    nxt_mem_wdata  = mem_wdata;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            next_state     = RESP;
            nxt_resp_valid = 1'b1;
            nxt_resp_err   = 1'b1;
            nxt_resp_rdata = '0;
          end else begin
            nxt_mem_addr = req_word;
            if (!req_we) begin
              next_state = READ;
              nxt_mem_re = 1'b1;
            end else if (req_funct3 == 3'd2) begin
              next_state    = WRITE;
              nxt_mem_wr    = 1'b1;
              nxt_mem_wdata = req_wdata;
            end else begin
              next_state = RMW_READ;
              nxt_mem_re = 1'b1;
            end
          end
        end
      end
      READ: begin
        next_state     = RESP;
        nxt_resp_valid = 1'b1;
        nxt_resp_err   = 1'b0;
        nxt_resp_rdata = ld_data;
      end
      RMW_READ: begin
        // Read strobe drops and write strobe rises on the same edge, same address
        next_state    = WRITE;
        nxt_mem_wr    = 1'b1;
        nxt_mem_wdata = rmw_word;
      end
      WRITE: begin
        next_state     = RESP;
        nxt_resp_valid = 1'b1;
        nxt_resp_err   = 1'b0;
        nxt_resp_rdata = '0;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    nxt_req_ready = (next_state == IDLE);
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      req_ready  <= nxt_req_ready;
      resp_valid <= nxt_resp_valid;
      resp_rdata <= nxt_resp_rdata;
      resp_err   <= nxt_resp_err;
      mem_addr   <= nxt_mem_addr;
      mem_re     <= nxt_mem_re;
      mem_wr     <= nxt_mem_wr;
      mem_wdata  <= nxt_mem_wdata;
    end
  end

  // Request capture on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_funct3 <= 3'd0;
      lat_off    <= 2'd0;
      lat_wdata  <= 16'h0000;
    end else if (state == IDLE && accept) begin
      lat_funct3 <= req_funct3;
      lat_off    <= req_addr[1:0];
      lat_wdata  <= req_wdata[15:0];
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master with a behavioural word memory and a
// response scoreboard (expected data, error flag and latency per accepted request).
module tb_lsu_mem_master;

  localparam int unsigned W  = 32;
  localparam int unsigned MS = 1024;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_we;
  logic [2:0]   req_funct3;
  logic [W-1:0] req_addr, req_wdata;
  logic         resp_valid, resp_err;
  logic [W-1:0] resp_rdata;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_re, mem_wr;

  lsu_mem_master #(.WIDTH(W), .MEM_SIZE(MS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory: level write sampled on the rising edge, combinational read
  logic [W-1:0] mem [0:MS-1];
  always @(posedge clk) if (mem_wr && mem_addr < MS) mem[mem_addr[9:0]] <= mem_wdata;
  assign mem_rdata = (mem_re && mem_addr < MS) ? mem[mem_addr[9:0]] : 32'h0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe activity counters
  int re_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0;
  logic [W-1:0] last_wa = '0, last_wd = '0;
  always @(negedge clk) begin
    if (mem_re) re_cnt <= re_cnt + 1;
    if (mem_wr) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_wdata;
    end
    if (mem_re && mem_wr) both_cnt <= both_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  typedef struct {
    logic [W-1:0] rdata;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_fail = 0;

  // Drive a request, wait for accept, push its expected response
  task automatic send(input logic we, input logic [2:0] f3, input logic [W-1:0] a,
                      input logic [W-1:0] d, input logic [W-1:0] er, input logic ee,
                      input int lat, input bit hold, output int acc);
    exp_t e;
    bit got = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin got = 1; break; end
      @(negedge clk);
    end
    acc = -1;
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout addr=%h: req_ready never high, required 1", a);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    e.rdata = er; e.err = ee; e.lat = lat; e.acc = acc;
    sb.push_back(e);
    if (!hold) req_valid = 1'b0;
  endtask

  // Wait for the next response and compare it with the scoreboard head
  task automatic sb_pop(input string name);
    exp_t e;
    bit got = 0;
    int lat;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1; break; end
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s resp_timeout: resp_valid never high, required 1", name);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected_resp: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    lat = cyc - e.acc + 1;
    if (resp_rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL %s rdata: got %h required %h", name, resp_rdata, e.rdata);
    end
    n_cmp++;
    if (resp_err !== e.err) begin
      n_fail++;
      $display("FAIL %s err: got %b required %b", name, resp_err, e.err);
    end
    n_cmp++;
    if (lat != e.lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, mem_re, mem_wr} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/rv/err/re/wr=%b required 10000",
               {req_ready, resp_valid, resp_err, mem_re, mem_wr});
    end
    n_cmp++;
    if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h required 0",
               resp_rdata, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sw();
    int acc, r0, w0;
    r0 = re_cnt; w0 = wr_cnt;
    send(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0, acc);
    sb_pop("sw_0x10");
    n_cmp++;
    if (wr_cnt - w0 != 1 || re_cnt - r0 != 0) begin
      n_fail++;
      $display("FAIL sw_strobes: got wr=%0d re=%0d required wr=1 re=0", wr_cnt - w0, re_cnt - r0);
    end
    n_cmp++;
    if (last_wa !== 32'd4 || last_wd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sw_write: got addr=%h data=%h required 4/deadbeef", last_wa, last_wd);
    end
  endtask

  task automatic test_loads();
    logic [2:0]   f3 [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd0};
    logic [W-1:0] ad [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
    logic [W-1:0] ex [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFFFEF};
    int acc, r0, w0;
    for (int i = 0; i < 5; i++) begin
      r0 = re_cnt; w0 = wr_cnt;
      send(1'b0, f3[i], ad[i], 32'h0, ex[i], 1'b0, 2, 1'b0, acc);
      sb_pop($sformatf("load%0d", i));
      n_cmp++;
      if (re_cnt - r0 != 1 || wr_cnt - w0 != 0) begin
        n_fail++;
        $display("FAIL load%0d_strobes: got re=%0d wr=%0d required re=1 wr=0", i, re_cnt - r0, wr_cnt - w0);
      end
    end
  endtask

  task automatic test_sub_word_store();
    logic [2:0]   f3 [2] = '{3'd0, 3'd1};
    logic [W-1:0] ad [2] = '{32'h11, 32'h12};
    logic [W-1:0] dt [2] = '{32'h00000055, 32'hAAAA1234};
    logic [W-1:0] ex [2] = '{32'hDEAD55EF, 32'h123455EF};
    int acc, r0, w0;
    for (int i = 0; i < 2; i++) begin
      r0 = re_cnt; w0 = wr_cnt;
      send(1'b1, f3[i], ad[i], dt[i], 32'h0, 1'b0, 3, 1'b0, acc);
      sb_pop($sformatf("rmw%0d", i));
      n_cmp++;
      if (re_cnt - r0 != 1 || wr_cnt - w0 != 1) begin
        n_fail++;
        $display("FAIL rmw%0d_strobes: got re=%0d wr=%0d required 1/1", i, re_cnt - r0, wr_cnt - w0);
      end
      n_cmp++;
      if (last_wa !== 32'd4 || last_wd !== ex[i]) begin
        n_fail++;
        $display("FAIL rmw%0d_write: got addr=%h data=%h required 4/%h", i, last_wa, last_wd, ex[i]);
      end
    end
    send(1'b0, 3'd2, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2, 1'b0, acc);
    sb_pop("rmw_readback");
  endtask

  task automatic test_errors();
    logic         we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]   f3 [4] = '{3'd2, 3'd1, 3'd3, 3'd2};
    logic [W-1:0] ad [4] = '{32'h12, 32'h03, 32'h10, 32'h1000};
    int acc, r0, w0;
    for (int i = 0; i < 4; i++) begin
      r0 = re_cnt; w0 = wr_cnt;
      send(we[i], f3[i], ad[i], 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b0, acc);
      sb_pop($sformatf("err%0d", i));
      n_cmp++;
      if (re_cnt - r0 != 0 || wr_cnt - w0 != 0) begin
        n_fail++;
        $display("FAIL err%0d_strobes: got re=%0d wr=%0d required 0/0", i, re_cnt - r0, wr_cnt - w0);
      end
    end
  endtask

  task automatic test_reset_rmw();
    int acc, w0, v0;
    send(1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b0, acc);
    sb_pop("rst_prefill");
    @(negedge clk);
    w0 = wr_cnt; v0 = resp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h20; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++;
    if (mem_re !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rmw_read: got mem_re=%b required 1", mem_re);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mem_re !== 1'b0 || mem_wr !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async: got re=%b wr=%b rdy=%b required 0/0/1", mem_re, mem_wr, req_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_cnt - w0 != 0 || resp_cnt - v0 != 0) begin
      n_fail++;
      $display("FAIL rst_dropped: got wr=%0d resp=%0d required 0/0", wr_cnt - w0, resp_cnt - v0);
    end
    n_cmp++;
    if (mem[8] !== 32'hCAFEF00D || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_state: got word8=%h rdy=%b required cafef00d/1", mem[8], req_ready);
    end
    send(1'b0, 3'd2, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b0, acc);
    sb_pop("rst_lw");
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, b0;
    b0 = both_cnt;
    send(1'b1, 3'd2, 32'h00, 32'h13579BDF, 32'h0, 1'b0, 2, 1'b1, acc1);
    sb_pop("b2b_sw");
    send(1'b0, 3'd2, 32'h00, 32'h0, 32'h13579BDF, 1'b0, 2, 1'b0, acc2);
    n_cmp++;
    if (acc2 - acc1 != 3) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles required 3", acc2 - acc1);
    end
    sb_pop("b2b_lw");
    n_cmp++;
    if (both_cnt - b0 != 0) begin
      n_fail++;
      $display("FAIL b2b_strobe_overlap: got %0d required 0", both_cnt - b0);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_loads();
    test_sub_word_store();
    test_errors();
    test_reset_rmw();
    test_back_to_back();
    n_cmp++;
    if (both_cnt != 0) begin
      n_fail++;
      $display("FAIL strobe_overlap_total: got %0d required 0", both_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
